clock_time_uart_tx: RTL and testbench

//  Reads the BCD time outputs of the 12-hour clock (hh, mm, ss, pm) and transmits them as ASCII

---
 rtl/clock_time_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_clock_time_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_uart_tx.sv
// Serialises the BCD 12-hour time as "HH:MM:SS AM\r\n" (13 chars) on a UART TX line.
// Define CLK_TX_PARITY_EN for an even parity bit after the data bits (8E1); default is 8N1.
module clock_time_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  CHAR_LAST = 4'd12;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_reg;
  logic [3:0]  char_reg;
  logic        pm_reg;
  logic [23:0] time_reg;
  logic        fin_reg;
  logic        txd_reg, busy_reg, done_reg, overrun_reg;
  logic        txd_next, busy_next, done_next, overrun_next;
  logic        bit_end, accept;
  logic [7:0]  digit_ascii [6];
  logic [7:0]  char_cur;

  assign bit_end = (cnt_reg == BIT_LAST);
  // fin_reg/done_reg hold off a new request until the cycle after the done pulse
  assign accept  = send && (state_reg == IDLE) && !fin_reg && !done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = time_reg[23 - 4*gi -: 4];
      assign digit_ascii[gi] = (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
    end
  endgenerate

  always_comb begin
    char_cur = 8'h0A;
    case (char_reg)
      4'd0:    char_cur = digit_ascii[0];
      4'd1:    char_cur = digit_ascii[1];
      4'd2:    char_cur = 8'h3A;
      4'd3:    char_cur = digit_ascii[2];
      4'd4:    char_cur = digit_ascii[3];
      4'd5:    char_cur = 8'h3A;
      4'd6:    char_cur = digit_ascii[4];
      4'd7:    char_cur = digit_ascii[5];
      4'd8:    char_cur = 8'h20;
      4'd9:    char_cur = pm_reg ? 8'h50 : 8'h41;
      4'd10:   char_cur = 8'h4D;
      4'd11:   char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = START;
      START:  if (bit_end) state_next = DATA;
      DATA:
        if (bit_end && bit_reg == 3'd7) begin
`ifdef CLK_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = (char_reg < CHAR_LAST) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd_next     = 1'b1;
    busy_next    = (state_reg != IDLE);
    done_next    = fin_reg;
    overrun_next = send && !accept;
    case (state_reg)
      START:   txd_next = 1'b0;
      DATA:    txd_next = char_cur[bit_reg];
      PARITY:  txd_next = ^char_cur;
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      bit_reg  <= '0;
      char_reg <= '0;
      pm_reg   <= 1'b0;
      time_reg <= '0;
      fin_reg  <= 1'b0;
    end else begin
      fin_reg <= 1'b0;
      if (accept) begin
        pm_reg   <= pm;
        time_reg <= {hh, mm, ss};
        cnt_reg  <= '0;
        bit_reg  <= '0;
        char_reg <= '0;
      end else if (state_reg != IDLE) begin
        if (bit_end) begin
          cnt_reg <= '0;
          if (state_reg == DATA) bit_reg <= bit_reg + 3'd1;
          if (state_reg == STOP) begin
            if (char_reg < CHAR_LAST) begin
              char_reg <= char_reg + 4'd1;
            end else begin
              char_reg <= '0;
              fin_reg  <= 1'b1;
            end
          end
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  end

  // Outputs are re-registered so every bit appears one edge after the state that produced it
  always_ff @(posedge clk) begin
    if (reset) begin
      txd_reg     <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      txd_reg     <= txd_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign txd     = txd_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_clock_time_uart_tx.sv
// Bench for clock_time_uart_tx: table vectors, random times against a string-level model,
// back-to-back sends, overrun and mid-message reset.
`timescale 1ns/1ps
module tb_clock_time_uart_tx;
  localparam int CPB = 4;
`ifdef CLK_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC   = FB * CPB;
  localparam int NMSG = 13 * FC;

  typedef struct {
    logic         p;
    logic [7:0]   h;
    logic [7:0]   m;
    logic [7:0]   s;
    logic [103:0] exp;
    int           send_at;
    bit           scr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic       pm = 1'b0;
  logic [7:0] hh = 8'h00;
  logic [7:0] mm = 8'h00;
  logic [7:0] ss = 8'h00;
  logic       txd, busy, done, overrun;

  int   n_checks = 0;
  int   n_fail = 0;
  logic cap [0:NMSG];

  clock_time_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .send(send), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .txd(txd), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, required test to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dig(input logic [3:0] n);
    string d = "0123456789";
    if (n < 4'd10) return d[n];
    return "?";
  endfunction

  function automatic logic [103:0] ref_msg(input logic p, input logic [7:0] h,
                                           input logic [7:0] m, input logic [7:0] s);
    logic [7:0]   c [13];
    logic [103:0] r;
    c[0] = dig(h[7:4]); c[1] = dig(h[3:0]); c[2] = ":";
    c[3] = dig(m[7:4]); c[4] = dig(m[3:0]); c[5] = ":";
    c[6] = dig(s[7:4]); c[7] = dig(s[3:0]); c[8] = " ";
    c[9] = p ? "P" : "A"; c[10] = "M"; c[11] = 8'h0D; c[12] = 8'h0A;
    for (int i = 0; i < 13; i++) r[8*(12-i) +: 8] = c[i];
    return r;
  endfunction

  task automatic start_msg();
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  // Called just after the acceptance edge; returns in the done cycle.
  task automatic run_msg(input logic [103:0] exp, input string name, input int send_at, input bit scramble);
    int         busy_err = 0, done_err = 0, wave_err = 0, ov_cnt = 0, ov_at = -1;
    int         idx, c, b;
    logic [7:0] ch, got;
    logic       expb;
    cap[0] = txd;
    for (int k = 1; k <= NMSG; k++) begin
      send = (send_at > 0) && (k == send_at);
      @(posedge clk); #1;
      cap[k] = txd;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if (overrun === 1'b1) begin ov_cnt++; ov_at = k; end
      if (scramble && k == 1) {pm, hh, mm, ss} = 25'($urandom);
    end
    send = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s done_pulse", name), 32'(done), 32'd1);
    check($sformatf("%s busy_clear", name), 32'(busy), 32'd0);
    for (int k = 0; k <= NMSG; k++) begin
      if (k == 0) begin
        expb = 1'b1;
      end else begin
        idx = k - 1;
        c = idx / FC;
        b = (idx % FC) / CPB;
        ch = exp[8*(12-c) +: 8];
        if (b == 0)                  expb = 1'b0;
        else if (b <= 8)             expb = ch[b-1];
        else if (b == 9 && FB == 11) expb = ^ch;
        else                         expb = 1'b1;
      end
      if (cap[k] !== expb) wave_err++;
    end
    check($sformatf("%s waveform_errs", name), 32'(wave_err), 32'd0);
    for (int ci = 0; ci < 13; ci++) begin
      ch = exp[8*(12-ci) +: 8];
      for (int bi = 0; bi < 8; bi++) got[bi] = cap[1 + ci*FC + (bi+1)*CPB + CPB/2];
      check($sformatf("%s char%0d", name, ci), 32'(got), 32'(ch));
`ifdef CLK_TX_PARITY_EN
      check($sformatf("%s parity%0d", name, ci), 32'(cap[1 + ci*FC + 9*CPB + CPB/2]), 32'(^ch));
`endif
    end
    check($sformatf("%s busy_errs", name), 32'(busy_err), 32'd0);
    check($sformatf("%s early_done", name), 32'(done_err), 32'd0);
    check($sformatf("%s overrun_count", name), 32'(ov_cnt), (send_at > 0) ? 32'd1 : 32'd0);
    if (send_at > 0) check($sformatf("%s overrun_cycle", name), 32'(ov_at), 32'(send_at));
    $display("msg %s: expected %h, overruns %0d, waveform errors %0d", name, exp, ov_cnt, wave_err);
  endtask

  initial begin
    vec_t         tbl [4];
    logic [103:0] e;
    int           idle_err;
    int           done_seen;

    tbl[0] = '{1'b0, 8'h12, 8'h00, 8'h00, "12:00:00 AM\r\n", 0,   1'b0};
    tbl[1] = '{1'b1, 8'h11, 8'h59, 8'h59, "11:59:59 PM\r\n", 100, 1'b1};
    tbl[2] = '{1'b0, 8'h1A, 8'h00, 8'h00, "1?:00:00 AM\r\n", 0,   1'b0};
    tbl[3] = '{1'b1, 8'h09, 8'h3F, 8'hF0, "09:3?:?0 PM\r\n", 0,   1'b0};

    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset txd", 32'(txd), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle_err = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) idle_err++;
    end
    check("post-reset idle", 32'(idle_err), 32'd0);

    // Each next vector is requested in the done cycle (dropped) and again one cycle later.
    {pm, hh, mm, ss} = {tbl[0].p, tbl[0].h, tbl[0].m, tbl[0].s};
    start_msg();
    for (int i = 0; i < 4; i++) begin
      run_msg(tbl[i].exp, $sformatf("vec%0d", i), tbl[i].send_at, tbl[i].scr);
      if (i < 3) begin
        {pm, hh, mm, ss} = {tbl[i+1].p, tbl[i+1].h, tbl[i+1].m, tbl[i+1].s};
        send = 1'b1;
        @(posedge clk); #1;
        check($sformatf("vec%0d done-cycle overrun", i), 32'(overrun), 32'd1);
        @(posedge clk); #1;
        check($sformatf("vec%0d next-cycle accept", i), 32'(overrun), 32'd0);
        send = 1'b0;
      end
    end
    @(posedge clk); #1;

    for (int r = 0; r < 3; r++) begin
      {pm, hh, mm, ss} = 25'($urandom);
      e = ref_msg(pm, hh, mm, ss);
      start_msg();
      run_msg(e, $sformatf("rand%0d", r), 0, 1'b0);
      @(posedge clk); #1;
    end

    {pm, hh, mm, ss} = {1'b1, 8'h07, 8'h34, 8'h56};
    start_msg();
    repeat (1 + 3*FC + 3*CPB) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset txd", 32'(txd), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    done_seen = 0;
    repeat (2*FC) begin
      @(posedge clk); #1;
      if (done === 1'b1 || txd !== 1'b1) done_seen++;
    end
    check("midreset no done, idle line", 32'(done_seen), 32'd0);
    start_msg();
    run_msg(ref_msg(pm, hh, mm, ss), "after_reset", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
